// File: rtl/mcu_dmi_pkg.sv
// -----------------------------------------------------------------------------
// mcu_dmi_pkg
// Shared types and defaults for the DMI clock-crossing blocks.
//   dmi_rsp_state_e : state encoding of the TCK-side response tracker
//   DMI_TIMEOUT_DEF : default number of TCK cycles to wait for a core completion
//   DMI_SYNC_DEF    : default synchronizer depth for the core acknowledge toggle
// -----------------------------------------------------------------------------
package mcu_dmi_pkg;

  typedef enum logic [1:0] {
    DMI_IDLE = 2'd0,
    DMI_WAIT = 2'd1,
    DMI_RESP = 2'd2
  } dmi_rsp_state_e;

  localparam int DMI_TIMEOUT_DEF = 200;
  localparam int DMI_SYNC_DEF    = 2;

endpackage : mcu_dmi_pkg

// File: rtl/mcu_dmi_tgl_sync.sv
// -----------------------------------------------------------------------------
// mcu_dmi_tgl_sync
// Brings the core-domain acknowledge toggle into the TCK domain and turns every
// level change into a one-cycle pulse.
//   clk      in  TCK
//   rst      in  synchronous reset, active-high
//   tgl      in  asynchronous toggle level from the core domain
//   ack_edge out one-cycle pulse per toggle, SYNC_STAGES+1 clk after the change
// -----------------------------------------------------------------------------
module mcu_dmi_tgl_sync
  import mcu_dmi_pkg::*;
#(
  parameter int SYNC_STAGES = DMI_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic ack_edge
);

  // Plain flop chain; the first stage is the metastability-catching flop.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   ack_edge_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= '0;
      hist_reg     <= 1'b0;
      ack_edge_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], tgl};
      // History follows the synchronized level unconditionally, so an edge is
      // reported once no matter what the consumer is doing.
      hist_reg     <= sync_out;
      // Registered edge so the consumer sees a clean flop output.
      ack_edge_reg <= sync_out ^ hist_reg;
    end
  end

  assign ack_edge = ack_edge_reg;

endmodule : mcu_dmi_tgl_sync

// File: rtl/mcu_dmi_core_to_jtag_sync.sv
// -----------------------------------------------------------------------------
// mcu_dmi_core_to_jtag_sync
// Return path of the DMI clock crossing (core completion -> TCK domain).
// Tracks one outstanding DMI access, waits for the core acknowledge toggle,
// captures read data and reports completion, timeout and overrun.
//   clk          in  TCK
//   rst          in  synchronous reset, active-high
//   rd_en        in  1-cycle read request
//   wr_en        in  1-cycle write request (wins over rd_en)
//   core_ack_tgl in  async toggle from core, one change per completion
//   core_rdata   in  async read data, stable from toggle until next request
//   err_clr      in  1-cycle clear of the sticky error bits
//   busy         out access outstanding (WAIT or RESP)
//   rsp_valid    out 1-cycle completion strobe
//   rsp_rdata    out captured read data, held until next capture
//   rsp_timeout  out sticky: access aborted by timeout
//   rsp_overrun  out sticky: request seen while busy
// -----------------------------------------------------------------------------
module mcu_dmi_core_to_jtag_sync
  import mcu_dmi_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = DMI_SYNC_DEF,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_CYC = DMI_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              core_ack_tgl,
  input  logic [DATA_W-1:0] core_rdata,
  input  logic              err_clr,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              rsp_overrun
);

  // Timer value on the last WAIT cycle before abort (unused when disabled).
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST =
    (TIMEOUT_CYC == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = {TIMEOUT_W{1'b1}};

  dmi_rsp_state_e    state_reg, state_next;
  logic              is_rd_reg, is_rd_next;
  logic [TIMEOUT_W-1:0] timer_reg, timer_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              timeout_reg, timeout_next;
  logic              overrun_reg, overrun_next;
  logic              ack_edge;
  logic              req;

  mcu_dmi_tgl_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tgl_sync (
    .clk      (clk),
    .rst      (rst),
    .tgl      (core_ack_tgl),
    .ack_edge (ack_edge)
  );

  assign req = rd_en | wr_en;

  // CDC waiver: core_rdata is sampled directly, without synchronization. It is
  // held stable by the core from its toggle onward, i.e. for well over
  // SYNC_STAGES clk before ack_edge enables the capture. Constrain the
  // core_rdata -> rdata_reg paths as false paths.
  always_comb begin
    state_next   = state_reg;
    is_rd_next   = is_rd_reg;
    timer_next   = timer_reg;
    rdata_next   = rdata_reg;
    // Clear first; any set below overrides it in the same cycle.
    timeout_next = timeout_reg & ~err_clr;
    overrun_next = overrun_reg & ~err_clr;
    case (state_reg)
      DMI_IDLE: begin
        // An ack_edge here is stale (post-reset mismatch or late ack): ignored.
        if (req) begin
          is_rd_next = rd_en & ~wr_en;
          timer_next = '0;
          state_next = DMI_WAIT;
        end
      end
      DMI_WAIT: begin
        if (timer_reg != TIMER_MAX) begin
          timer_next = timer_reg + 1'b1;
        end
        if (req) begin
          overrun_next = 1'b1;
        end
        // Acknowledge has priority over a coincident timeout.
        if (ack_edge) begin
          if (is_rd_reg) begin
            rdata_next = core_rdata;
          end
          state_next = DMI_RESP;
        end else if ((TIMEOUT_CYC != 0) && (timer_reg == TIMER_LAST)) begin
          if (is_rd_reg) begin
            rdata_next = '0;
          end
          timeout_next = 1'b1;
          state_next   = DMI_RESP;
        end
      end
      DMI_RESP: begin
        if (req) begin
          overrun_next = 1'b1;
        end
        state_next = DMI_IDLE;
      end
      default: begin
        state_next = DMI_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DMI_IDLE;
      is_rd_reg   <= 1'b0;
      timer_reg   <= '0;
      rdata_reg   <= '0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      is_rd_reg   <= is_rd_next;
      timer_reg   <= timer_next;
      rdata_reg   <= rdata_next;
      timeout_reg <= timeout_next;
      overrun_reg <= overrun_next;
    end
  end

  assign busy        = (state_reg != DMI_IDLE);
  assign rsp_valid   = (state_reg == DMI_RESP);
  assign rsp_rdata   = rdata_reg;
  assign rsp_timeout = timeout_reg;
  assign rsp_overrun = overrun_reg;

endmodule : mcu_dmi_core_to_jtag_sync
